// File: rtl/ncl_sync_pkg.sv
// ncl_sync_pkg: shared types and dual-rail helpers for the NCL-to-synchronous merge
package ncl_sync_pkg;
  typedef enum logic [1:0] {CH_S, CH_T, CH_U, CH_V} ch_e;
  typedef enum logic [1:0] {WAIT_DATA, HOLD, WAIT_NULL} state_e;
  function automatic logic dr_is_data(input logic [1:0] p);
    return p[1] ^ p[0];
  endfunction
  function automatic logic dr_is_null(input logic [1:0] p);
    return ~|p;
  endfunction
  function automatic logic dr_is_illegal(input logic [1:0] p);
    return &p;
  endfunction
  function automatic logic dr_to_sr(input logic [1:0] p);
    return p[1];
  endfunction
endpackage

// File: rtl/ncl_dr_word_detect.sv
// ncl_dr_word_detect: qualifies DATA/NULL completion of a synced dual-rail word with a stability count
module ncl_dr_word_detect
  import ncl_sync_pkg::*;
#(
  parameter int W          = 32,
  parameter int STABLE_CYC = 2
) (
  input  logic           clk,
  input  logic           init,
  input  logic [2*W-1:0] dr,
  input  logic           clear,
  output logic           data_ok,
  output logic           null_ok,
  output logic           illegal
);
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] SC = CW'(STABLE_CYC);
  logic [W-1:0] bit_data, bit_null, bit_ill;
  logic [2*W-1:0] prev;
  logic [CW-1:0] run, run_cur;
  for (genvar g = 0; g < W; g++) begin : g_bit
    assign bit_data[g] = dr_is_data(dr[2*g +: 2]);
    assign bit_null[g] = dr_is_null(dr[2*g +: 2]);
    assign bit_ill[g]  = dr_is_illegal(dr[2*g +: 2]);
  end
  assign illegal = |bit_ill;
  // run_cur counts consecutive cycles, including this one, that dr has held its value
  assign run_cur = dr != prev ? CW'(1) : run == SC ? SC : run + CW'(1);
  assign data_ok = &bit_data && run_cur == SC;
  assign null_ok = &bit_null && run_cur == SC;
  // remember last sample and run length; illegal words and channel switches restart the run
  always_ff @(posedge clk or posedge init)
    if (init) begin
      prev <= '0;
      run  <= '0;
    end else begin
      prev <= dr;
      run  <= clear || illegal ? '0 : run_cur;
    end
endmodule

// File: rtl/ncl_steer_merge4_sync.sv
// ncl_steer_merge4_sync: merges four NCL channels in ring order into one clocked valid/ready word stream
module ncl_steer_merge4_sync
  import ncl_sync_pkg::*;
#(
  parameter int W           = 32,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 2
) (
  input  logic           clk,
  input  logic           init,
  input  logic [2*W-1:0] s_dr,
  input  logic [2*W-1:0] t_dr,
  input  logic [2*W-1:0] u_dr,
  input  logic [2*W-1:0] v_dr,
  output logic           s_ki,
  output logic           t_ki,
  output logic           u_ki,
  output logic           v_ki,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [1:0]     out_ch,
  output logic           err_illegal,
  output logic [31:0]    word_cnt
);
  logic [8*W-1:0] sync_q [SYNC_STAGES];
  logic [2*W-1:0] cur;
  logic [W-1:0] sr;
  logic [3:0] ki;
  ch_e ptr;
  state_e state, state_d;
  logic data_ok, null_ok, illegal, null_seen, acc_data, acc_null, xfer;
  assign {v_ki, u_ki, t_ki, s_ki} = ki;
  assign cur = sync_q[SYNC_STAGES-1][int'(ptr)*2*W +: 2*W];
  assign xfer = out_valid && out_ready;
  for (genvar g = 0; g < W; g++) begin : g_sr
    assign sr[g] = dr_to_sr(cur[2*g +: 2]);
  end
  ncl_dr_word_detect #(.W(W), .STABLE_CYC(STABLE_CYC)) u_det (
    .clk(clk),
    .init(init),
    .dr(cur),
    .clear(acc_null),
    .data_ok(data_ok),
    .null_ok(null_ok),
    .illegal(illegal)
  );
  // synchronise every rail of every channel before it is looked at
  always_ff @(posedge clk or posedge init)
    if (init) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {v_dr, u_dr, t_dr, s_dr};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  // handshake FSM: accept DATA, hold until taken, then wait for NULL (possibly already seen)
  always_comb begin
    state_d  = state;
    acc_data = 1'b0;
    acc_null = 1'b0;
    case (state)
      WAIT_DATA: begin
        acc_data = data_ok;
        state_d  = data_ok ? HOLD : WAIT_DATA;
      end
      HOLD: begin
        acc_null = xfer && (null_seen || null_ok);
        state_d  = !xfer ? HOLD : acc_null ? WAIT_DATA : WAIT_NULL;
      end
      WAIT_NULL: begin
        acc_null = null_ok;
        state_d  = null_ok ? WAIT_DATA : WAIT_NULL;
      end
      default: state_d = WAIT_DATA;
    endcase
  end
  // output register, acknowledges, ring pointer and counters
  always_ff @(posedge clk or posedge init)
    if (init) begin
      state       <= WAIT_DATA;
      ptr         <= CH_S;
      ki          <= '1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ch      <= '0;
      err_illegal <= 1'b0;
      word_cnt    <= '0;
      null_seen   <= 1'b0;
    end else begin
      state       <= state_d;
      null_seen   <= state == HOLD && !xfer && (null_seen || null_ok);
      err_illegal <= err_illegal | illegal;
      if (acc_data) begin
        out_data  <= sr;
        out_ch    <= ptr;
        out_valid <= 1'b1;
        ki[ptr]   <= 1'b0;
      end
      if (xfer) begin
        out_valid <= 1'b0;
        word_cnt  <= word_cnt + 32'd1;
      end
      if (acc_null) begin
        ki[ptr] <= 1'b1;
        ptr     <= ch_e'(ptr + 2'd1);
      end
    end
endmodule

// File: tb/tb_ncl_steer_merge4_sync.sv
// tb_ncl_steer_merge4_sync: randomized scoreboard bench for the four-channel NCL merge
module tb_ncl_steer_merge4_sync;
  logic clk = 1'b0;
  logic init = 1'b1;
  logic [63:0] s_dr = '0, t_dr = '0, u_dr = '0, v_dr = '0;
  logic s_ki, t_ki, u_ki, v_ki, out_valid, err_illegal;
  logic out_ready = 1'b1;
  logic [31:0] out_data, word_cnt;
  logic [1:0] out_ch;
  logic [3:0] ki;
  int checks = 0, failures = 0, n_words = 0;
  logic [33:0] exp_q[$];
  logic [31:0] cq[4][$];
  logic done = 1'b0;
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [33:0] prev_d = '0;

  assign ki = {v_ki, u_ki, t_ki, s_ki};
  always #5 clk = ~clk;

  ncl_steer_merge4_sync dut (
    .clk(clk), .init(init),
    .s_dr(s_dr), .t_dr(t_dr), .u_dr(u_dr), .v_dr(v_dr),
    .s_ki(s_ki), .t_ki(t_ki), .u_ki(u_ki), .v_ki(v_ki),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .err_illegal(err_illegal), .word_cnt(word_cnt)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] enc(input logic [31:0] w);
    logic [63:0] e;
    for (int i = 0; i < 32; i++) e[2*i +: 2] = {w[i], ~w[i]};
    return e;
  endfunction

  // model: words leave strictly in ring order, so the n-th word comes from channel n mod 4
  task automatic exp_push(input logic [31:0] w);
    exp_q.push_back({2'(n_words % 4), w});
    n_words++;
  endtask

  task automatic set_ch(input int c, input logic [63:0] v);
    case (c)
      0: s_dr = v;
      1: t_dr = v;
      2: u_dr = v;
      default: v_dr = v;
    endcase
  endtask

  task automatic wait_ki(input int c, input logic val);
    int n = 0;
    while (ki[c] !== val && n < 600) begin
      tick();
      n++;
    end
    check($sformatf("ki%0d_wait", c), 64'(ki[c]), 64'(val));
  endtask

  task automatic send_dr(input int c, input logic [63:0] dr);
    wait_ki(c, 1'b1);
    set_ch(c, dr);
    wait_ki(c, 1'b0);
    set_ch(c, '0);
  endtask

  task automatic send(input int c, input logic [31:0] w);
    send_dr(c, enc(w));
  endtask

  task automatic chan(input int c);
    while (cq[c].size() > 0) begin
      repeat ($urandom_range(0, 3)) tick();
      send(c, cq[c].pop_front());
    end
  endtask

  // monitor: every transfer is matched against the head of the expected queue
  always @(negedge clk) begin
    if (init) prev_v <= 1'b0;
    else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected", {out_ch, out_data}, 64'h0);
        else check("sb_word", {out_ch, out_data}, exp_q.pop_front());
      end
      if (prev_v && !prev_r && out_valid) check("hold_stable", {out_ch, out_data}, prev_d);
      prev_v <= out_valid;
      prev_r <= out_ready;
      prev_d <= {out_ch, out_data};
    end
  end

  initial begin
    logic [63:0] ring_dr [4];
    logic [31:0] ring_w [4];
    logic [63:0] v, part;
    logic [31:0] w, wt, wu;
    logic early;
    int n;
    ring_dr = '{64'h5555_5555_5555_5556, 64'hAAAA_AAAA_AAAA_AAAA,
                64'h5555_5555_5555_5555, 64'h5555_5555_5555_5559};
    ring_w = '{32'h1, 32'hFFFF_FFFF, 32'h0, 32'h2};
    repeat (3) tick();
    check("rst_ki", 64'(ki), 64'hF);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_cnt", 64'(word_cnt), 64'h0);
    check("rst_err", 64'(err_illegal), 64'h0);
    check("rst_data", 64'(out_data), 64'h0);
    init = 1'b0;
    tick();
    // ring order with the canonical rail patterns
    for (int c = 0; c < 4; c++) begin
      exp_push(ring_w[c]);
      send_dr(c, ring_dr[c]);
    end
    wait_ki(3, 1'b1);
    check("ring_cnt", 64'(word_cnt), 64'd4);
    // skewed arrival on S, then backpressure while held
    out_ready = 1'b0;
    w = $urandom;
    exp_push(w);
    v = enc(w);
    part = '0;
    early = 1'b0;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 32; i++) if (i * 10 / 32 == k) part[2*i +: 2] = v[2*i +: 2];
      s_dr = part;
      if (k < 9) begin
        tick();
        early = early | out_valid;
      end
    end
    repeat (3) tick();
    check("skew_early", 64'(early | out_valid), 64'h0);
    tick();
    check("skew_latency", 64'(out_valid), 64'h1);
    repeat (20) begin
      tick();
      check("bp_valid", 64'(out_valid), 64'h1);
      check("bp_s_ki", 64'(s_ki), 64'h0);
    end
    out_ready = 1'b1;
    s_dr = '0;
    wait_ki(0, 1'b1);
    // U presents DATA while T is current: U must wait its turn
    wt = $urandom;
    wu = $urandom;
    exp_push(wt);
    exp_push(wu);
    set_ch(2, enc(wu));
    repeat (10) begin
      tick();
      check("oot_u_ki", 64'(u_ki), 64'h1);
      check("oot_valid", 64'(out_valid), 64'h0);
    end
    send(1, wt);
    wait_ki(2, 1'b0);
    set_ch(2, '0);
    wait_ki(2, 1'b1);
    w = $urandom;
    exp_push(w);
    send(3, w);
    // illegal rail pair on S, then repaired
    w = $urandom;
    v = enc(w);
    v[1:0] = 2'b11;
    set_ch(0, v);
    repeat (8) tick();
    check("ill_err", 64'(err_illegal), 64'h1);
    check("ill_valid", 64'(out_valid), 64'h0);
    check("ill_s_ki", 64'(s_ki), 64'h1);
    exp_push(w);
    send(0, w);
    wait_ki(0, 1'b1);
    check("ill_sticky", 64'(err_illegal), 64'h1);
    // random traffic: all channels offer words concurrently, random backpressure
    for (int k = 0; k < 24; k++) begin
      w = $urandom;
      cq[n_words % 4].push_back(w);
      exp_push(w);
    end
    fork
      begin
        fork
          chan(0);
          chan(1);
          chan(2);
          chan(3);
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (exp_q.size() > 0 && n < 600) begin
      tick();
      n++;
    end
    repeat (8) tick();
    check("drain_empty", 64'(exp_q.size()), 64'h0);
    check("final_cnt", 64'(word_cnt), 64'(n_words));
    // reset while a word is held
    out_ready = 1'b0;
    set_ch(n_words % 4, enc($urandom));
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("pre_rst_valid", 64'(out_valid), 64'h1);
    #2 init = 1'b1;
    #1;
    check("mid_rst_ki", 64'(ki), 64'hF);
    check("mid_rst_valid", 64'(out_valid), 64'h0);
    check("mid_rst_cnt", 64'(word_cnt), 64'h0);
    check("mid_rst_err", 64'(err_illegal), 64'h0);
    s_dr = '0;
    t_dr = '0;
    u_dr = '0;
    v_dr = '0;
    tick();
    init = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
